gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Parametrised, handshaked successor to the board-level GCD datapath: computes gcd(a, b) of two unsigned WIDTH-bit operands with an iterative subtract-based Euclid FSM.
- Sits between the switch/DIP input registers and the LED display logic. Any future operand source can drive it through a start/done handshake instead of continuous combinational evaluation.
- Adds an error flag for the undefined gcd(0,0) case.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A, unsigned; sampled on the accepted start edge.
- b  input  WIDTH  operand B, unsigned; sampled on the accepted start edge.
- busy  output  1  high while in CALC or DONE.
- done  output  1  one-cycle completion pulse.
- gcd  output  WIDTH  result register; holds its value until the next completion.
- err  output  1  high when the last completed operation had a=b=0.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, gcd=0, err=0, internal x=y=0.
- Reset mid-operation: the operation is aborted immediately, with no done pulse and gcd cleared to 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at a rising edge latches x<=a, y<=b and moves to CALC.
  - start=0 stays in IDLE.
- CALC: one step per cycle, evaluated in this priority order:
  - x==0 or y==0: gcd<=x|y; err<=(x==0 && y==0); go to DONE.
  - x==y: gcd<=x; err<=0; go to DONE.
  - x>y: x<=x-y.
  - otherwise: y<=y-x.
- DONE: done=1 for exactly this one cycle, then IDLE unconditionally.
- busy=1 in CALC and DONE, 0 in IDLE.
- Latency: start edge, then N CALC cycles, then 1 DONE cycle. The next start can be accepted on the cycle after DONE.
- Worst case N is 2^WIDTH-1 cycles (operands 2^WIDTH-1 and 1).
- start while busy is ignored; it is neither queued nor able to corrupt x/y.
- a/b changes after acceptance have no effect.
- Arithmetic: all unsigned. Subtraction never underflows because only the larger operand is reduced. No width growth.
- gcd and err change only on the CALC-to-DONE transition. Both remain stable through DONE and IDLE.
- Boundaries:
  - a=0, b=0 gives gcd=0, err=1, N=1.
  - Exactly one operand zero gives gcd = the other operand, err=0, N=1.
  - a==b (nonzero) gives gcd=a, N=1.

Optional Feature:
- Macro GCD_CYCLE_COUNT_EN.
- When defined:
  - Adds output port cycles [WIDTH-1:0]: the number of CALC cycles used by the last completed operation.
  - Internal counter clears to 0 on the accepted start and increments each CALC cycle.
  - The counter is copied to cycles on the CALC-to-DONE transition.
  - cycles resets to 0 asynchronously.
  - Counter width WIDTH is sufficient since N ≤ 2^WIDTH-1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset low for 5 cycles, then released → busy=0, done=0, gcd=0, err=0. Assert rst_n low mid-CALC of a=255, b=1 → immediate IDLE, gcd=0, no done pulse.
- a=10, b=5, 1-cycle start pulse → 2 CALC cycles; done pulses on the 3rd cycle after the start edge; gcd=5, err=0; cycles=2 if GCD_CYCLE_COUNT_EN.
- a=12, b=8 → 12,8 → 4,8 → 4,4; gcd=4, done on the 4th cycle after the start edge; cycles=3.
- Edge operands:
  - a=0, b=0 → gcd=0, err=1, cycles=1.
  - a=7, b=0 → gcd=7, err=0, cycles=1.
  - a=9, b=9 → gcd=9, cycles=1.
- WIDTH=8, a=255, b=1 → gcd=1, cycles=255. During busy, pulse start with a=6, b=4 and toggle a/b → ignored; result is still 1. A start on the cycle after DONE is accepted → gcd=2.
- Back-to-back random pairs, 200 iterations at WIDTH=8 and WIDTH=16 → each gcd matches the reference-model gcd. done is high exactly once per accepted start; busy never drops between start and done.

Source files
------------

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - handshaked subtract-based Euclid GCD engine; define GCD_CYCLE_COUNT_EN to add the cycles output
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic             err
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [WIDTH-1:0] cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] gcd_nxt;
  logic             err_nxt;

  // Operand comparisons used by the CALC step; the zero tests take priority
  logic x_zero;
  logic y_zero;
  logic x_eq_y;
  logic x_gt_y;
  logic accept;
  logic calc_last;

  // Decode the current operand relationship for this CALC step
  always_comb begin
    x_zero    = (x == '0);
    y_zero    = (y == '0);
    x_eq_y    = (x == y);
    x_gt_y    = (x > y);
    accept    = (state == IDLE) && start;
    calc_last = (state == CALC) && (x_zero || y_zero || x_eq_y);
  end

  // State, operand and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      gcd   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      gcd   <= gcd_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state, one Euclid subtraction per CALC cycle, and the handshake outputs
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    gcd_nxt   = gcd;
    err_nxt   = err;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // Operands are captured only here, so later a/b activity cannot disturb x/y
        if (start) begin
          x_nxt     = a;
          y_nxt     = b;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (x_zero || y_zero) begin
          // gcd(n,0)=n; gcd(0,0) is undefined and flagged
          gcd_nxt   = x | y;
          err_nxt   = x_zero && y_zero;
          state_nxt = DONE;
        end else if (x_eq_y) begin
          gcd_nxt   = x;
          err_nxt   = 1'b0;
          state_nxt = DONE;
        end else if (x_gt_y) begin
          // Only the larger value is reduced, so no underflow is possible
          x_nxt = x - y;
        end else begin
          y_nxt = y - x;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cnt;

  // Count CALC cycles; the final CALC cycle is included when publishing to cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      cycles <= '0;
    end else begin
      if (accept) begin
        cnt <= '0;
      end else if (calc_last) begin
        cycles <= cnt + WIDTH'(1);
      end else if (state == CALC) begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - directed and random self-checking bench for gcd_engine at WIDTH=8 and WIDTH=16
module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy8, done8, err8;
  logic [7:0]  gcd8;
  logic        busy16, done16, err16;
  logic [15:0] gcd16;
`ifdef GCD_CYCLE_COUNT_EN
  logic [7:0]  cycles8;
  logic [15:0] cycles16;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gcd(gcd8), .err(err8)
`ifdef GCD_CYCLE_COUNT_EN
    , .cycles(cycles8)
`endif
  );

  gcd_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .gcd(gcd16), .err(err16)
`ifdef GCD_CYCLE_COUNT_EN
    , .cycles(cycles16)
`endif
  );

  function automatic int unsigned ref_gcd(input int unsigned p, input int unsigned q);
    int unsigned t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic int sub_steps(input int unsigned p, input int unsigned q);
    int n = 1;
    while (p != 0 && q != 0 && p != q && n < 2000) begin
      if (p > q) p = p - q;
      else q = q - p;
      n++;
    end
    return n;
  endfunction

  // lat counts clock cycles after the start edge until done is seen (-1 on timeout)
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int budget,
                      output int lat, output bit busy_drop, output int after_done, output int after_busy);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    busy_drop = 1'b0;
    while (!done8 && lat < budget) begin
      if (!busy8) busy_drop = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!done8) lat = -1;
    else if (!busy8) busy_drop = 1'b1;
    @(negedge clk);
    after_done = int'(done8);
    after_busy = int'(busy8);
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input int budget,
                       output int lat, output bit busy_drop, output int after_done);
    @(negedge clk);
    a16 = av; b16 = bv; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    busy_drop = 1'b0;
    while (!done16 && lat < budget) begin
      if (!busy16) busy_drop = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!done16) lat = -1;
    else if (!busy16) busy_drop = 1'b1;
    @(negedge clk);
    after_done = int'(done16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
    checks++; if (gcd8 !== 8'd0) begin errors++; $display("FAIL reset_gcd: got %0d expected 0", gcd8); end
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err8); end
`ifdef GCD_CYCLE_COUNT_EN
    checks++; if (cycles8 !== 8'd0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", cycles8); end
`endif
  endtask

  task automatic test_basic();
    int lat, ad, ab;
    bit bd;
    run8(8'd10, 8'd5, 50, lat, bd, ad, ab);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic10_5_latency: got %0d expected 3", lat); end
    checks++; if (gcd8 !== 8'd5) begin errors++; $display("FAIL basic10_5_gcd: got %0d expected 5", gcd8); end
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL basic10_5_err: got %b expected 0", err8); end
    checks++; if (bd !== 1'b0 || ad !== 0 || ab !== 0) begin errors++; $display("FAIL basic10_5_handshake: busy_drop=%0d done_after=%0d busy_after=%0d expected 0 0 0", bd, ad, ab); end
`ifdef GCD_CYCLE_COUNT_EN
    checks++; if (cycles8 !== 8'd2) begin errors++; $display("FAIL basic10_5_cycles: got %0d expected 2", cycles8); end
`endif
    run8(8'd12, 8'd8, 50, lat, bd, ad, ab);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic12_8_latency: got %0d expected 4", lat); end
    checks++; if (gcd8 !== 8'd4) begin errors++; $display("FAIL basic12_8_gcd: got %0d expected 4", gcd8); end
`ifdef GCD_CYCLE_COUNT_EN
    checks++; if (cycles8 !== 8'd3) begin errors++; $display("FAIL basic12_8_cycles: got %0d expected 3", cycles8); end
`endif
  endtask

  task automatic test_edges();
    int lat, ad, ab;
    bit bd;
    logic [7:0] ea, eb, eg;
    logic ee;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin ea = 8'd0; eb = 8'd0; eg = 8'd0; ee = 1'b1; end
        1: begin ea = 8'd7; eb = 8'd0; eg = 8'd7; ee = 1'b0; end
        2: begin ea = 8'd0; eb = 8'd7; eg = 8'd7; ee = 1'b0; end
        default: begin ea = 8'd9; eb = 8'd9; eg = 8'd9; ee = 1'b0; end
      endcase
      run8(ea, eb, 20, lat, bd, ad, ab);
      checks++; if (lat !== 2) begin errors++; $display("FAIL edge%0d_latency: got %0d expected 2", i, lat); end
      checks++; if (gcd8 !== eg) begin errors++; $display("FAIL edge%0d_gcd: got %0d expected %0d", i, gcd8, eg); end
      checks++; if (err8 !== ee) begin errors++; $display("FAIL edge%0d_err: got %b expected %b", i, err8, ee); end
`ifdef GCD_CYCLE_COUNT_EN
      checks++; if (cycles8 !== 8'd1) begin errors++; $display("FAIL edge%0d_cycles: got %0d expected 1", i, cycles8); end
`endif
    end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy8); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy8); end
    checks++; if (gcd8 !== 8'd0) begin errors++; $display("FAIL midreset_gcd: got %0d expected 0", gcd8); end
    repeat (3) begin
      @(negedge clk);
      if (done8) dones++;
    end
    rst_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (done8) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d done pulses expected 0", dones); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midreset_idle: got busy %b expected 0", busy8); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 400) begin
      a8 = 8'(lat * 3);
      b8 = ~8'(lat);
      if (lat == 5 || lat == 200) begin a8 = 8'd6; b8 = 8'd4; start8 = 1'b1; end
      else start8 = 1'b0;
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    if (!done8) lat = -1;
    checks++; if (lat !== 256) begin errors++; $display("FAIL ignore_latency: got %0d expected 256", lat); end
    checks++; if (gcd8 !== 8'd1) begin errors++; $display("FAIL ignore_gcd: got %0d expected 1", gcd8); end
`ifdef GCD_CYCLE_COUNT_EN
    checks++; if (cycles8 !== 8'd255) begin errors++; $display("FAIL ignore_cycles: got %0d expected 255", cycles8); end
`endif
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL after_done_idle: got busy %b expected 0", busy8); end
    a8 = 8'd6; b8 = 8'd4; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!done8) lat = -1;
    checks++; if (lat !== 4) begin errors++; $display("FAIL restart_latency: got %0d expected 4", lat); end
    checks++; if (gcd8 !== 8'd2) begin errors++; $display("FAIL restart_gcd: got %0d expected 2", gcd8); end
  endtask

  task automatic test_back_to_back();
    int lat, ad, ab;
    bit bd;
    logic [7:0] av, bv;
    logic [7:0] eg;
    for (int i = 0; i < 200; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      if (i % 23 == 0) bv = 8'd0;
      eg = 8'(ref_gcd(int'(av), int'(bv)));
      run8(av, bv, 300, lat, bd, ad, ab);
      checks++;
      if (gcd8 !== eg || err8 !== (av == 0 && bv == 0)) begin
        errors++; $display("FAIL rand8 a=%0d b=%0d: got gcd %0d err %b expected gcd %0d", av, bv, gcd8, err8, eg);
      end
      checks++;
      if (lat < 2 || bd || ad != 0) begin
        errors++; $display("FAIL rand8_handshake a=%0d b=%0d: latency %0d busy_drop %0d done_after %0d", av, bv, lat, bd, ad);
      end
    end
  endtask

  task automatic test_back_to_back_w16();
    int lat, ad, n;
    bit bd;
    logic [15:0] av, bv, eg;
    for (int i = 0; i < 200; i++) begin
      av = 16'd48; bv = 16'd36;
      for (int t = 0; t < 50; t++) begin
        av = 16'($urandom_range(0, 65535));
        bv = 16'($urandom_range(0, 65535));
        if (sub_steps(int'(av), int'(bv)) <= 300) break;
        av = 16'd48; bv = 16'd36;
      end
      n = sub_steps(int'(av), int'(bv));
      eg = 16'(ref_gcd(int'(av), int'(bv)));
      run16(av, bv, n + 10, lat, bd, ad);
      checks++;
      if (gcd16 !== eg || err16 !== (av == 0 && bv == 0)) begin
        errors++; $display("FAIL rand16 a=%0d b=%0d: got gcd %0d err %b expected gcd %0d", av, bv, gcd16, err16, eg);
      end
      checks++;
      if (lat < 2 || bd || ad != 0) begin
        errors++; $display("FAIL rand16_handshake a=%0d b=%0d: latency %0d busy_drop %0d done_after %0d", av, bv, lat, bd, ad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_mid_reset();
    test_busy_ignore();
    test_back_to_back();
    test_back_to_back_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
